// File: rtl/bcd_cascade_counter.sv
// Cascaded BCD counter with per-digit modulus, load/clear and carry chain.
// Saturates instead of wrapping at terminal count when WRAP_EN is 0.
module bcd_cascade_counter #(
    parameter int DIGITS  = 4,
    parameter bit WRAP_EN = 1'b1
) (
    input  logic                  i_time_clk,
    input  logic                  i_sys_rst,
    input  logic [4*DIGITS-1:0]   i_mod_value,
    input  logic                  i_count_carry_in,
    input  logic                  i_count_dir,
    input  logic                  i_clear,
    input  logic                  i_load,
    input  logic [4*DIGITS-1:0]   i_load_value,
    output logic [4*DIGITS-1:0]   o_count,
    output logic                  o_count_carry_out
);

    logic [3:0]          cur [DIGITS];
    logic [3:0]          eff [DIGITS];
    logic [DIGITS-1:0]   term;
    logic [DIGITS-1:0]   step;
    logic [4*DIGITS-1:0] stepped;
    logic [4*DIGITS-1:0] ld_val;
    logic                carry_raw;

    // Out-of-range moduli fall back to decimal.
    always_comb begin
        for (int k = 0; k < DIGITS; k++) begin
            cur[k] = o_count[4*k +: 4];
            if (i_mod_value[4*k +: 4] >= 4'd1 &&
                i_mod_value[4*k +: 4] <= 4'd10)
                eff[k] = i_mod_value[4*k +: 4];
            else
                eff[k] = 4'd10;
            if (i_count_dir)
                term[k] = (cur[k] >= eff[k] - 4'd1);
            else
                term[k] = (cur[k] == 4'd0);
        end
    end

    always_comb begin
        step    = '0;
        step[0] = i_count_carry_in;
        for (int k = 1; k < DIGITS; k++)
            step[k] = step[k-1] & term[k-1];
    end

    assign carry_raw = i_count_carry_in & (&term);

    assign o_count_carry_out = carry_raw & ~i_clear &
                               ~i_load & i_sys_rst;

    always_comb begin
        stepped = o_count;
        for (int k = 0; k < DIGITS; k++) begin
            if (step[k]) begin
                if (i_count_dir)
                    stepped[4*k +: 4] = term[k] ? 4'd0
                                                : cur[k] + 4'd1;
                else
                    stepped[4*k +: 4] = term[k] ? eff[k] - 4'd1
                                                : cur[k] - 4'd1;
            end
        end
    end

    // Non-BCD load nibbles are forced to zero.
    always_comb begin
        ld_val = '0;
        for (int k = 0; k < DIGITS; k++) begin
            if (i_load_value[4*k +: 4] <= 4'd9)
                ld_val[4*k +: 4] = i_load_value[4*k +: 4];
        end
    end

    always_ff @(posedge i_time_clk or negedge i_sys_rst) begin
        if (!i_sys_rst)
            o_count <= '0;
        else if (i_clear)
            o_count <= '0;
        else if (i_load)
            o_count <= ld_val;
        else if (!WRAP_EN && carry_raw)
            o_count <= o_count;
        else
            o_count <= stepped;
    end

endmodule

// File: doc/bcd_cascade_counter.md
BCD_CASCADE_COUNTER -- requirements
Module: bcd_cascade_counter

Interface
REQ-001 Parameter DIGITS, default 4: number of cascaded BCD digits (1..8).
REQ-002 Parameter WRAP_EN, default 1: 1 = wrap at terminal count, 0 = saturate at terminal count.
REQ-003 Port i_time_clk  input  1  single clock; all state updates on its rising edge.
REQ-004 Port i_sys_rst  input  1  reset, asynchronous, active-low.
REQ-005 Port i_mod_value  input  4*DIGITS  per-digit modulus; nibble k = M_k for digit k (digit 0 = LSD).
REQ-006 Port i_count_carry_in  input  1  count enable / cascade carry-in; one step per high cycle.
REQ-007 Port i_count_dir  input  1  direction: 1 = up, 0 = down.
REQ-008 Port i_clear  input  1  synchronous clear to all-zero.
REQ-009 Port i_load  input  1  synchronous parallel load.
REQ-010 Port i_load_value  input  4*DIGITS  load data, nibble k for digit k.
REQ-011 Port o_count  output  4*DIGITS  registered counter value, nibble k = digit k.
REQ-012 Port o_count_carry_out  output  1  combinational cascade carry/borrow out.

Function
REQ-013 Effective modulus E_k SHALL be M_k for M_k in 1..10, else 10; digit k counts 0..E_k-1.
REQ-014 Priority on each edge SHALL be i_clear > i_load > count step; clear/load need no enable.
REQ-015 Load SHALL write i_load_value nibble-wise; any nibble >9 SHALL be written as 0; no range check against E_k.
REQ-016 Up terminal for digit k: value >= E_k-1. Down terminal for digit k: value == 0.
REQ-017 Digit 0 step-in = i_count_carry_in; digit k step-in = step-in of k-1 AND digit k-1 terminal (current direction).
REQ-018 Up step with digit non-terminal: value+1; up step at terminal: 0.
REQ-019 Down step with digit non-terminal: value-1; down step at terminal: E_k-1.
REQ-020 o_count_carry_out SHALL = i_count_carry_in AND all digits terminal in current direction, and SHALL be 0 when i_clear or i_load is high.
REQ-021 WRAP_EN=0: when o_count_carry_out would be 1, o_count SHALL hold; o_count_carry_out SHALL still assert.
REQ-022 Latency: o_count SHALL reflect a step, clear or load one edge after it is sampled; carry-out has zero latency.
REQ-023 A change of i_mod_value or i_count_dir SHALL take effect on the same edge; there is no hidden state besides o_count.
REQ-024 Chaining o_count_carry_out into the next instance's i_count_carry_in SHALL behave as one wider counter on the same clock.

Reset
REQ-025 While i_sys_rst=0, o_count SHALL be 0 immediately, independent of the clock.
REQ-026 o_count_carry_out SHALL be 0 during reset.
REQ-027 Deassertion SHALL be synchronised externally; the first step SHALL occur on the first edge with i_sys_rst=1 and enable high.
REQ-028 Reset asserted mid-count SHALL discard all progress; no partial-digit update is retained.

Verification
REQ-029 DIGITS=4, all M=10, up, enable held 10000 cycles from 0 -> o_count 9999 after 9999 edges; carry_out high only that cycle; 0000 after the next edge.
REQ-030 M={6,10} (2 digits, MSD=6), up, from 59 with enable -> carry_out=1 and o_count 00 next edge; from 09 -> 10, no carry.
REQ-031 Down, all M=10, from 0000 with enable -> carry_out=1, then 9999; from 0100 -> 0099.
REQ-032 WRAP_EN=0, up, at 9999 with enable for 5 cycles -> o_count stays 9999, carry_out high all 5 cycles.
REQ-033 i_load=1, i_load_value=0x12F4, i_clear=0, enable=1 -> o_count 0x1204 next edge, carry_out 0; i_clear and i_load both high -> 0000.
REQ-034 Assert i_sys_rst=0 between clock edges at 0437 -> o_count 0000 before the next edge; release -> counting resumes from 0000.
